// File: rtl/ps2_keyb_rx.sv
// PS/2 keyboard receive deframer: synchronizes and filters the pads, deframes
// 11-bit frames and folds E0/F0 prefixes into flags on a single-cycle strobe.
module ps2_keyb_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       msoc_clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] scan_code,
  output logic       scan_released,
  output logic       scan_extended,
  output logic       scan_ready,
  output logic       frame_err,
  output logic [7:0] err_count
);

  localparam int unsigned FLT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned WD_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_REL = 8'hF0;
  localparam logic [7:0] ERR_MAX  = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             r_clk_s1;
  logic             r_clk_s2;
  logic             r_dat_s1;
  logic             r_dat_s2;
  logic             r_clk_filt;
  logic             r_clk_filt_d;
  logic [FLT_W-1:0] r_filt_cnt;
  logic [WD_W-1:0]  r_wdog;
  logic [2:0]       r_bitcnt;
  logic [7:0]       r_shift;
  logic             r_par;
  logic             r_ext_pend;
  logic             r_rel_pend;

  logic w_fall;
  logic w_dat;
  logic w_wd_expired;
  logic w_timeout;
  logic w_clr_cnt;
  logic w_shift_en;
  logic w_par_en;
  logic w_frame_end;
  logic w_good;
  logic w_bad;

  // Pad synchronizers and clock glitch filter; everything idles high.
  always_ff @(posedge msoc_clk) begin
    if (rst) begin
      r_clk_s1     <= 1'b1;
      r_clk_s2     <= 1'b1;
      r_dat_s1     <= 1'b1;
      r_dat_s2     <= 1'b1;
      r_clk_filt   <= 1'b1;
      r_clk_filt_d <= 1'b1;
      r_filt_cnt   <= '0;
    end else begin
      r_clk_s1     <= ps2_clk_i;
      r_clk_s2     <= r_clk_s1;
      r_dat_s1     <= ps2_data_i;
      r_dat_s2     <= r_dat_s1;
      r_clk_filt_d <= r_clk_filt;
      if (r_clk_s2 == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FLT_W'(FILTER_LEN - 1)) begin
        r_clk_filt <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  assign w_fall       = r_clk_filt_d & ~r_clk_filt;
  assign w_dat        = r_dat_s2;
  assign w_wd_expired = (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));
  // A falling edge in the same cycle as expiry wins over the timeout.
  assign w_timeout    = (r_state != S_IDLE) && w_wd_expired && !w_fall;

  always_ff @(posedge msoc_clk) begin
    if (rst || w_fall || w_timeout || (r_state == S_IDLE)) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  always_ff @(posedge msoc_clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr_cnt   = 1'b0;
    w_shift_en  = 1'b0;
    w_par_en    = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall && !w_dat) begin
          w_state_nxt = S_DATA;
          w_clr_cnt   = 1'b1;
        end
      end
      S_DATA: begin
        if (w_fall) begin
          w_shift_en = 1'b1;
          if (r_bitcnt == 3'd7) begin
            w_state_nxt = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (w_fall) begin
          w_par_en    = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_fall) begin
          w_frame_end = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Odd parity: data plus parity bit must XOR to 1, and the stop bit must be 1.
  assign w_good = w_frame_end & w_dat & (^{r_par, r_shift});
  assign w_bad  = (w_frame_end & ~w_good) | w_timeout;

  always_ff @(posedge msoc_clk) begin
    if (rst) begin
      r_bitcnt      <= '0;
      r_shift       <= '0;
      r_par         <= 1'b0;
      r_ext_pend    <= 1'b0;
      r_rel_pend    <= 1'b0;
      scan_code     <= '0;
      scan_released <= 1'b0;
      scan_extended <= 1'b0;
      scan_ready    <= 1'b0;
      frame_err     <= 1'b0;
      err_count     <= '0;
    end else begin
      scan_ready <= 1'b0;
      frame_err  <= 1'b0;
      if (w_clr_cnt) begin
        r_bitcnt <= '0;
      end
      if (w_shift_en) begin
        r_shift  <= {w_dat, r_shift[7:1]};
        r_bitcnt <= r_bitcnt + 3'd1;
      end
      if (w_par_en) begin
        r_par <= w_dat;
      end
      if (w_good) begin
        if (r_shift == CODE_EXT) begin
          r_ext_pend <= 1'b1;
        end else if (r_shift == CODE_REL) begin
          r_rel_pend <= 1'b1;
        end else begin
          scan_code     <= r_shift;
          scan_released <= r_rel_pend;
          scan_extended <= r_ext_pend;
          scan_ready    <= 1'b1;
          r_ext_pend    <= 1'b0;
          r_rel_pend    <= 1'b0;
        end
      end
      if (w_bad) begin
        frame_err  <= 1'b1;
        r_ext_pend <= 1'b0;
        r_rel_pend <= 1'b0;
        if (err_count != ERR_MAX) begin
          err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyb_rx.sv
// Directed bench for ps2_keyb_rx: expected key events are queued as frames are
// sent and compared when scan_ready fires.
module tb_ps2_keyb_rx;

  localparam int unsigned FL   = 4;
  localparam int unsigned TO   = 300;
  localparam int unsigned HALF = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       scan_released;
  logic       scan_extended;
  logic       scan_ready;
  logic       frame_err;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  ps2_keyb_rx #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .msoc_clk     (clk),
    .rst          (rst),
    .ps2_clk_i    (ps2_clk),
    .ps2_data_i   (ps2_data),
    .scan_code    (scan_code),
    .scan_released(scan_released),
    .scan_extended(scan_extended),
    .scan_ready   (scan_ready),
    .frame_err    (frame_err),
    .err_count    (err_count)
  );

  typedef struct packed {
    logic [7:0] code;
    logic       rel;
    logic       ext;
  } ev_t;

  ev_t q[$];
  int  n_chk      = 0;
  int  n_fail     = 0;
  int  n_ferr     = 0;
  int  exp_ferr   = 0;
  int  exp_errcnt = 0;
  bit  m_rel      = 1'b0;
  bit  m_ext      = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pop on scan_ready, frame_err pulse counting.
  always @(negedge clk) begin
    ev_t e;
    if (scan_ready === 1'b1 || frame_err === 1'b1) begin
      n_chk++;
      assert (!(scan_ready === 1'b1 && frame_err === 1'b1)) else begin
        n_fail++;
        $error("FAIL strobe_overlap: observed ready=%0b err=%0b expected not both", scan_ready, frame_err);
      end
    end
    if (frame_err === 1'b1) n_ferr++;
    if (scan_ready === 1'b1) begin
      n_chk++;
      assert (q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_ready: observed code %0h expected no strobe", scan_code);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("scan_code", 32'(scan_code), 32'(e.code));
        chk("scan_released", 32'(scan_released), 32'(e.rel));
        chk("scan_extended", 32'(scan_extended), 32'(e.ext));
      end
    end
  end

  task automatic wcyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      wcyc(2);
      ps2_clk = 1'b0;
      wcyc(FL - 1);
      ps2_clk = 1'b1;
    end
    wcyc(HALF);
    ps2_clk = 1'b0;
    wcyc(HALF);
    ps2_clk = 1'b1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop, input bit glitch);
    logic [10:0] f;
    f = mk_frame(d, bad_par, bad_stop);
    if (bad_par || bad_stop) begin
      exp_ferr++;
      if (exp_errcnt < 255) exp_errcnt++;
      m_rel = 1'b0;
      m_ext = 1'b0;
    end else if (d == 8'hE0) begin
      m_ext = 1'b1;
    end else if (d == 8'hF0) begin
      m_rel = 1'b1;
    end else begin
      q.push_back({d, m_rel, m_ext});
      m_rel = 1'b0;
      m_ext = 1'b0;
    end
    for (int i = 0; i < 11; i++) ps2_bit(f[i], glitch && (i == 5));
    ps2_data = 1'b1;
    wcyc(HALF + 10);
  endtask

  task automatic send_partial(input logic [7:0] d, input int nbits);
    logic [10:0] f;
    f = mk_frame(d, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(f[i], 1'b0);
    ps2_data = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_queue"}, 32'(q.size()), 32'd0);
    chk({tag, "_ferr_pulses"}, 32'(n_ferr), 32'(exp_ferr));
    chk({tag, "_err_count"}, 32'(err_count), 32'(exp_errcnt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed simulation still running expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int base;
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wcyc(3);
    chk("rst_scan_code", 32'(scan_code), 32'd0);
    chk("rst_released", 32'(scan_released), 32'd0);
    chk("rst_extended", 32'(scan_extended), 32'd0);
    chk("rst_ready", 32'(scan_ready), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;
    wcyc(20);

    send_frame(8'h1C, 0, 0, 0);
    check_idle("plain_1c");
    chk("hold_1c", 32'(scan_code), 32'h1C);

    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h74, 0, 0, 0);
    check_idle("e0f0_74");
    chk("hold_74_rel", 32'(scan_released), 32'd1);
    send_frame(8'h1C, 0, 0, 0);
    check_idle("after_74");
    chk("flags_cleared", 32'({scan_released, scan_extended}), 32'd0);

    send_frame(8'h1C, 1, 0, 0);
    check_idle("bad_parity");
    chk("bad_parity_errcnt", 32'(err_count), 32'd1);

    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h33, 1, 0, 0);
    send_frame(8'h1C, 0, 0, 0);
    check_idle("f0_bad_1c");

    send_partial(8'h55, 5);
    wcyc(TO + 10);
    exp_ferr++;
    exp_errcnt++;
    m_rel = 1'b0;
    m_ext = 1'b0;
    check_idle("timeout");
    send_frame(8'h2B, 0, 0, 0);
    check_idle("after_timeout");
    chk("hold_2b", 32'(scan_code), 32'h2B);

    wcyc(5);
    ps2_clk = 1'b0;
    wcyc(FL - 1);
    ps2_clk = 1'b1;
    wcyc(20);
    send_frame(8'h3A, 0, 0, 1);
    check_idle("glitch");
    chk("hold_3a", 32'(scan_code), 32'h3A);

    send_frame(8'hF0, 0, 0, 0);
    send_partial(8'h4D, 4);
    rst = 1'b1;
    wcyc(2);
    rst = 1'b0;
    exp_errcnt = 0;
    m_rel = 1'b0;
    m_ext = 1'b0;
    wcyc(20);
    check_idle("mid_reset");
    chk("mid_reset_code", 32'(scan_code), 32'd0);
    send_frame(8'h4D, 0, 0, 0);
    check_idle("after_reset");
    chk("hold_4d_rel", 32'(scan_released), 32'd0);

    base = n_ferr;
    for (int i = 0; i < 260; i++) send_frame(8'(i), 0, 1, 0);
    check_idle("saturate");
    chk("saturate_errcnt", 32'(err_count), 32'd255);
    chk("saturate_pulses", 32'(n_ferr - base), 32'd260);
    send_frame(8'h1C, 0, 0, 0);
    check_idle("after_saturate");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
